pc_sequencer: RTL
=================

# pc_sequencer

Owns the program counter and sequences instruction fetch for the single-cycle-execute datapath, choosing the next PC from the five next-PC sources: sequential, register, jump immediate, conditional branch, and return-to-OS. It adds a fetch handshake to instruction memory, a HALT state, and a preemption quantum timer that forces a trap to the OS entry point and saves the interrupted PC. It sits between the control unit/ULA, the instruction memory port and the PC register consumers.

## Interface
- `WIDTH`, 32, PC and operand width.
- `OS_ENTRY`, 524, trap/return target address.
- `QUANTUM`, 64, retired instructions per time slice (≥2).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `PCDst` in 3: next-PC select from control: 0 seq, 1 reg, 2 jump, 3 branch, 4 OS; 5–7 treated as 0.
- `ULACrl` in 1: branch-taken flag from ULA.
- `reg_data` in WIDTH: register bank data 1.
- `jump_imm` in WIDTH: jump target.
- `branch_imm` in WIDTH: branch target.
- `halt` in 1: current instruction is HLT.
- `preempt_en` in 1: quantum timer armed (user process running).
- `fetch_ack` in 1: instruction memory has instruction for `pc`.
- `pc` out WIDTH: current PC; reset 0.
- `fetch_req` out 1: fetch request; reset 0.
- `retire` out 1: one-cycle pulse, instruction executes this cycle; reset 0.
- `os_trap` out 1: one-cycle pulse with retire when next PC is OS_ENTRY; reset 0.
- `saved_pc` out WIDTH: PC to resume after trap; reset 0.
- `halted` out 1: in HALT; reset 0.

## Operation
- FSM states: FETCH, EXEC, HALT. After reset release: FETCH with pc=0.
- FETCH: `fetch_req`=1, `pc` stable; on `fetch_ack` go to EXEC. `fetch_ack` outside FETCH ignored.
- EXEC: `retire`=1 for exactly one cycle; compute next PC, load `pc`, return to FETCH.
- Next PC: 0 → pc+1; 1 → reg_data; 2 → jump_imm; 3 → branch_imm if ULACrl else pc+1; 4 → OS_ENTRY.
- pc+1 wraps modulo 2^WIDTH.
- PCDst=4: `os_trap`=1, `saved_pc` ← pc+1.
- Quantum counter: increments on each retire while `preempt_en`=1; cleared on any trap or when `preempt_en`=0. On the retire where count = QUANTUM-1: next PC forced to OS_ENTRY, `saved_pc` ← the normally computed next PC, `os_trap`=1, counter clears.
- Simultaneous PCDst=4 and quantum expiry: single trap, `saved_pc` ← pc+1, counter clears.
- `halt` in EXEC: highest priority; no trap, pc unchanged, go to HALT, `halted`=1. HALT exits only via reset.
- `saved_pc` holds its value between traps.

## Timing
- Minimum 2 cycles per instruction (FETCH with same-cycle ack, then EXEC).
- `pc` updates on the clock edge ending EXEC; visible in the following FETCH.
- `fetch_req` may stay high for unbounded wait; no timeout.
- Reset mid-FETCH or mid-EXEC: next cycle all outputs at reset values, no retire/trap emitted.
- `retire` and `os_trap` never assert in FETCH or HALT.

## Configuration
- `PC_SEQ_PREEMPT_EN` defined: quantum counter and forced traps present as above.
- Undefined: counter absent, `preempt_en` ignored, traps only from PCDst=4; QUANTUM unused.

## Structure
- Package `pc_seq_pkg`: FSM state typedef, PCDst encodings (PC_SEQ, PC_REG, PC_JUMP, PC_BRANCH, PC_OS), default OS_ENTRY.
- Sub-module `quantum_timer`: counter with inc/clear/expire; instantiated only under `PC_SEQ_PREEMPT_EN`.

## Test plan
- Reset, ack every FETCH, PCDst=0 ×3 → pc 0,1,2,3; retire pulses every 2nd cycle.
- pc=10, PCDst=3, ULACrl=1, branch_imm=40 → pc=40; repeat with ULACrl=0 → pc=11.
- pc=7, PCDst=4 → pc=524, os_trap pulse, saved_pc=8.
- QUANTUM=4, preempt_en=1, PCDst=2 jump_imm=100 on 4th retire → pc=524, saved_pc=100, os_trap=1.
- halt=1 with PCDst=4 at pc=5 → halted=1, pc=5, no os_trap; stays until reset.
- fetch_ack held low 5 cycles then reset low mid-FETCH → fetch_req=0, pc=0 next cycle, no retire.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared FSM states, next-PC select encodings and the default
// OS entry address for the PC sequencer.
package pc_seq_pkg;
    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;
    localparam logic [2:0] PC_SEQ    = 3'd0;
    localparam logic [2:0] PC_REG    = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_BRANCH = 3'd3;
    localparam logic [2:0] PC_OS     = 3'd4;
    localparam int DEFAULT_OS_ENTRY  = 524;
endpackage

// File: rtl/quantum_timer.sv
// quantum_timer: counts retires of a user time slice; o_expire flags the
// retire that completes the slice, after which the count restarts.
module quantum_timer #(
    parameter int QUANTUM = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clear,
    output logic o_expire
);
    localparam int CW = $clog2(QUANTUM);
    logic [CW-1:0] r_count;
    assign o_expire = i_inc && r_count == CW'(QUANTUM - 1);
    always_ff @(posedge clock) begin
        if (!reset || i_clear || o_expire)
            r_count <= '0;
        else if (i_inc)
            r_count <= r_count + 1'b1;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, runs FETCH/EXEC/HALT and picks the next PC.
// Define PC_SEQ_PREEMPT_EN to add the quantum timer that forces OS traps.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int OS_ENTRY = DEFAULT_OS_ENTRY,
    parameter int QUANTUM  = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       PCDst,
    input  logic             ULACrl,
    input  logic [WIDTH-1:0] reg_data,
    input  logic [WIDTH-1:0] jump_imm,
    input  logic [WIDTH-1:0] branch_imm,
    input  logic             halt,
    input  logic             preempt_en,
    input  logic             fetch_ack,
    output logic [WIDTH-1:0] pc,
    output logic             fetch_req,
    output logic             retire,
    output logic             os_trap,
    output logic [WIDTH-1:0] saved_pc,
    output logic             halted
);
    state_t           r_state, w_next_state;
    logic [WIDTH-1:0] r_pc, r_saved_pc, w_pc_inc, w_norm_pc, w_next_pc;
    logic             r_fetch_req, w_exec, w_os_req, w_expire, w_trap;

    always_comb begin
        w_exec       = r_state == ST_EXEC;
        w_pc_inc     = r_pc + 1'b1;
        w_norm_pc    = PCDst == PC_REG                ? reg_data :
                       PCDst == PC_JUMP               ? jump_imm :
                       PCDst == PC_BRANCH && ULACrl   ? branch_imm :
                       PCDst == PC_OS                 ? WIDTH'(OS_ENTRY) : w_pc_inc;
        w_os_req     = w_exec && !halt && PCDst == PC_OS;
        w_trap       = w_os_req || w_expire;
        w_next_pc    = halt ? r_pc : w_trap ? WIDTH'(OS_ENTRY) : w_norm_pc;
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: w_next_state = r_fetch_req && fetch_ack ? ST_EXEC : ST_FETCH;
            ST_EXEC:  w_next_state = halt ? ST_HALT : ST_FETCH;
            default:  w_next_state = ST_HALT;
        endcase
    end

`ifdef PC_SEQ_PREEMPT_EN
    quantum_timer #(.QUANTUM(QUANTUM)) u_quantum (
        .clock    (clock),
        .reset    (reset),
        .i_inc    (w_exec && preempt_en && !halt),
        .i_clear  (!preempt_en || w_os_req),
        .o_expire (w_expire)
    );
`else
    logic w_unused;
    assign w_expire = 1'b0;
    assign w_unused = preempt_en ^ (QUANTUM > 1);
`endif

    // fetch_req is registered so it reads 0 on the cycle after a reset edge
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_FETCH;
            r_pc        <= '0;
            r_saved_pc  <= '0;
            r_fetch_req <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_fetch_req <= w_next_state == ST_FETCH;
            if (w_exec)
                r_pc <= w_next_pc;
            if (w_trap)
                r_saved_pc <= w_os_req ? w_pc_inc : w_norm_pc;
        end
    end

    assign pc        = r_pc;
    assign fetch_req = r_fetch_req;
    assign retire    = w_exec;
    assign os_trap   = w_trap;
    assign saved_pc  = r_saved_pc;
    assign halted    = r_state == ST_HALT;
endmodule
